// File: rtl/prf_pkg.sv
// Package: prf_pkg
// Shared definitions for param_register_file and its scoreboard.
//   prf_state_e    : sequencer state (PRF_INIT loads registers, PRF_RUN serves reads/writes)
//   PRF_INIT_ZERO  : INIT_MODE value, every register initialised to zero
//   PRF_INIT_INDEX : INIT_MODE value, register i initialised to i
package prf_pkg;

  typedef enum logic {
    PRF_INIT = 1'b0,
    PRF_RUN  = 1'b1
  } prf_state_e;

  localparam int PRF_INIT_ZERO  = 0;
  localparam int PRF_INIT_INDEX = 1;

endpackage

// File: rtl/prf_scoreboard.sv
// Module: prf_scoreboard
// Per-register pending bits for in-flight results, with a busy lookup for
// both read ports. Built only when PRF_SCOREBOARD_EN is defined.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   clear                 : drop every pending bit (file is initialising)
//   issue_en, issue_reg   : mark issue_reg pending
//   wr_accept, write_reg  : accepted write-back, clears pending[write_reg]
//   read_reg1, read_reg2  : lookup addresses
//   busy1, busy2          : pending bit of the looked-up register (combinational)
module prf_scoreboard #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              wr_accept,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic              busy1,
  output logic              busy2
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_next;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Clear from the write first, then set from the issue, so an issue and a
  // write-back to the same register in one cycle leave the bit set.
  always_comb begin
    pending_next = pending;
    if (wr_accept && addr_ok(write_reg)) pending_next[write_reg] = 1'b0;
    if (issue_en && addr_ok(issue_reg)) pending_next[issue_reg] = 1'b1;
    if (ZERO_R0 != 0) pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (clear) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (addr_ok(read_reg1)) busy1 = pending[read_reg1];
    if (addr_ok(read_reg2)) busy2 = pending[read_reg2];
  end

endmodule

// File: rtl/param_register_file.sv
// Module: param_register_file
// General-purpose register file: two registered read ports (1-cycle latency),
// one write port with write-to-read bypass, optional hardwired-zero R0, and a
// post-reset sequencer that loads every register before reporting ready.
// Optional feature macro: PRF_SCOREBOARD_EN (adds issue/busy scoreboard ports).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   init_req                 : request re-initialisation (honoured in RUN only)
//   ready                    : file is in RUN
//   read_reg1, read_reg2     : read addresses
//   write_reg, write_data,
//   write_enable             : write port
//   read_data1, read_data2   : registered read data
//   state_dbg                : current sequencer state
//   issue_en, issue_reg,
//   busy1, busy2             : scoreboard (PRF_SCOREBOARD_EN only)
module param_register_file
  import prf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int ZERO_R0   = 1,
  parameter int INIT_MODE = PRF_INIT_INDEX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              ready,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output prf_state_e        state_dbg
`ifdef PRF_SCOREBOARD_EN
  ,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              busy1,
  output logic              busy2
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  prf_state_e        state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] init_val;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;
  logic [DATA_W-1:0] rd_next1;
  logic [DATA_W-1:0] rd_next2;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // ready is a level, not a handshake: while it is low (INIT) the write port
  // and init_req are ignored and both read ports return 0; while it is high
  // every cycle's write and reads are taken without back-pressure.
  assign ready     = (state == PRF_RUN);
  assign state_dbg = state;

  assign init_val  = (INIT_MODE == PRF_INIT_INDEX) ? DATA_W'(init_ptr) : '0;

  assign wr_accept = (state == PRF_RUN) && write_enable && addr_ok(write_reg) &&
                     !((ZERO_R0 != 0) && (write_reg == '0));

  // Read mux: out-of-range and hardwired R0 read 0; a write accepted this
  // cycle to the same address is forwarded so the port sees the new value.
  always_comb begin
    rd_next1 = '0;
    if (addr_ok(read_reg1) && !((ZERO_R0 != 0) && (read_reg1 == '0))) begin
      if (wr_accept && (write_reg == read_reg1)) rd_next1 = write_data;
      else                                       rd_next1 = mem[read_reg1];
    end
  end

  always_comb begin
    rd_next2 = '0;
    if (addr_ok(read_reg2) && !((ZERO_R0 != 0) && (read_reg2 == '0))) begin
      if (wr_accept && (write_reg == read_reg2)) rd_next2 = write_data;
      else                                       rd_next2 = mem[read_reg2];
    end
  end

  // Storage carries no reset; the INIT sequence gives it known contents.
  // While rst is held the state is INIT with init_ptr 0, so only entry 0 is
  // touched, and it is reloaded once the sequence runs.
  always_ff @(posedge clk) begin
    if (state == PRF_INIT) begin
      mem[init_ptr] <= init_val;
    end else if (wr_accept) begin
      mem[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRF_INIT;
      init_ptr   <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      case (state)
        PRF_INIT: begin
          read_data1 <= '0;
          read_data2 <= '0;
          if (init_ptr == LAST_IDX) begin
            state    <= PRF_RUN;
            init_ptr <= '0;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        PRF_RUN: begin
          read_data1 <= rd_next1;
          read_data2 <= rd_next2;
          if (init_req) begin
            state    <= PRF_INIT;
            init_ptr <= '0;
          end
        end
        default: begin
          state    <= PRF_INIT;
          init_ptr <= '0;
        end
      endcase
    end
  end

`ifdef PRF_SCOREBOARD_EN
  prf_scoreboard #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == PRF_INIT),
    .issue_en  (issue_en),
    .issue_reg (issue_reg),
    .wr_accept (wr_accept),
    .write_reg (write_reg),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .busy1     (busy1),
    .busy2     (busy2)
  );
`endif

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised general-purpose register file for the multi-cycle RISC datapath.
- Two synchronous read ports with 1-cycle latency and one synchronous write port.
- Write-to-read bypass, optional hardwired-zero R0, and a post-reset initialisation sequencer that loads every register before asserting ready.
- Sits between the decode stage (read addresses) and the write-back stage (write port).

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; must be at least 2.
- ADDR_W, $clog2(DEPTH), address width.
- ZERO_R0, 1, when 1 R0 always reads 0 and writes to R0 are discarded.
- INIT_MODE, 1, init value per register: 0 = all zeros; 1 = register index (reg i = i, zero-extended).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- init_req  input  1  request re-initialisation; sampled in RUN only.
- ready  output  1  high when the file is in RUN.
- read_reg1  input  ADDR_W  read port 1 address.
- read_reg2  input  ADDR_W  read port 2 address.
- write_reg  input  ADDR_W  write address.
- write_data  input  DATA_W  write data.
- write_enable  input  1  write strobe.
- read_data1  output  DATA_W  registered read data, port 1.
- read_data2  output  DATA_W  registered read data, port 2.

Behaviour:
- Reset (async, while rst=1): read_data1/2=0, ready=0, state=INIT, init_ptr=0. The register array itself is not reset; it is loaded by the INIT sequence.
- INIT state, one register per clock:
  - Writes reg[init_ptr] with 0 (INIT_MODE=0) or init_ptr (INIT_MODE=1), then increments init_ptr.
  - After writing DEPTH-1, moves to RUN. ready=1 exactly DEPTH rising edges after rst deasserts.
  - During INIT: write_enable and init_req are ignored; read_data1/2 are held at 0.
- RUN state:
  - Write: at posedge, if write_enable=1, write_reg<DEPTH, and not (ZERO_R0 and write_reg=0), then reg[write_reg] <= write_data.
  - Read: every posedge, read_dataN <= reg[read_regN]. Latency is 1 cycle.
  - Bypass: if a write is accepted in the same cycle and write_reg==read_regN, read_dataN <= write_data (the new value, not the old one).
  - Any read with ZERO_R0=1 and read_regN=0, or with read_regN>=DEPTH, returns 0.
  - Both ports may read the same address in the same cycle; each returns identical data.
- init_req=1 in RUN:
  - Next state is INIT, init_ptr=0, ready drops on that edge.
  - A write in the same cycle is still performed, but will be overwritten by INIT.
- rst asserted mid-INIT or mid-RUN restarts the INIT sequence from index 0.
- States (from the shared package): INIT, RUN.

Optional Feature:
- Macro: PRF_SCOREBOARD_EN.
- With the macro defined:
  - Added ports: issue_en (in, 1), issue_reg (in, ADDR_W), busy1 (out, 1), busy2 (out, 1).
  - Per-register pending bit vector of width DEPTH.
  - issue_en sets pending[issue_reg]; an accepted write clears pending[write_reg].
  - If issue and write target the same register in the same cycle, the pending bit stays set.
  - busyN = pending[read_regN], combinational.
  - R0 is never pending when ZERO_R0=1.
  - rst and INIT clear all pending bits; issue_en is ignored in INIT.
- Without the macro: these ports and the pending logic do not exist.

Decomposition:
- Package prf_pkg:
  - state enum {PRF_INIT, PRF_RUN}.
  - Constants PRF_INIT_ZERO=0 and PRF_INIT_INDEX=1.
- One sub-module: prf_scoreboard, holding the pending vector and busy lookup. Instantiated only under PRF_SCOREBOARD_EN.

Test Plan:
- Init with defaults: deassert rst → ready=0 for 32 edges, then 1. Reads of reg 5 and reg 31 return 0x5 and 0x1F one cycle after the address is presented.
- Write then read: write reg 7=0xDEADBEEF with read_reg1=7 in the same cycle → read_data1=0xDEADBEEF after 1 edge (bypass). Next cycle, read_reg2=7 → 0xDEADBEEF.
- R0 protection: write reg 0=0x12345678 → read_reg1=0 returns 0. With ZERO_R0=0, it returns 0x12345678.
- Re-init: after writing reg 3=0xAA, pulse init_req → ready falls on the next edge, rises 32 edges later, and reg 3 reads 0x3. Writes issued during INIT are lost.
- Mid-op reset: assert rst during the RUN-state write of reg 9=0x55 → read_data1/2=0 immediately and ready=0. After release, reg 9 reads 0x9 once ready rises.
- PRF_SCOREBOARD_EN: issue reg 4 → busy1=1 with read_reg1=4. Issue and write reg 4 in the same cycle → busy stays 1. A write to reg 4 alone → busy1=0 the next cycle.
